// File: rtl/apb_slave_pkg.sv
// Shared types and address-decode helper for the APB memory completer.
package apb_slave_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READY
  } apb_state_e;

  localparam int unsigned DEF_DEPTH = 64;
  localparam int unsigned OFF_W     = $clog2(DEF_DEPTH) + 2;

  // Error when below the window, past its last word, or not word aligned.
  function automatic logic apb_decode_err(input logic [31:0]   addr,
                                          input logic [31:0]   base,
                                          input int unsigned   depth);
    logic [31:0] off;
    off = addr - base;
    return (addr < base) || (off >= 32'(4 * depth)) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// DEPTH x DATA_W storage: one synchronous write port, one combinational read port.
module apb_slave_regfile
  import apb_slave_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer: word-addressed memory with programmable wait states and PSLVERR.
module apb_slave_mem
  import apb_slave_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Psel,
  input  logic              Penable,
  input  logic              Pwrite,
  input  logic [31:0]       Paddr,
  input  logic [DATA_W-1:0] Pwdata,
  output logic [DATA_W-1:0] Prdata,
  output logic              Pready,
  output logic              Pslverr
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

  apb_state_e        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [IDX_W-1:0]  lat_idx, lat_idx_n;
  logic              lat_write, lat_write_n;
  logic              lat_err, lat_err_n;
  logic [DATA_W-1:0] lat_wdata, lat_wdata_n;
  logic [DATA_W-1:0] prdata_n;
  logic              pready_n, pslverr_n;

  logic [IDX_W-1:0]  idx_in, ridx;
  logic              err_in, src_err, src_write;
  logic [DATA_W-1:0] rdata;
  logic              we;

  assign idx_in = IDX_W'((Paddr - BASE_ADDR) >> 2);
  assign err_in = apb_decode_err(Paddr, BASE_ADDR, DEPTH);

  // Zero-wait transfers load the response straight from the setup-phase inputs.
  assign src_err   = (state == IDLE) ? err_in : lat_err;
  assign src_write = (state == IDLE) ? Pwrite : lat_write;
  assign ridx      = (state == IDLE) ? idx_in : lat_idx;

  apb_slave_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .widx  (lat_idx),
    .wdata (lat_wdata),
    .ridx  (ridx),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_idx   <= '0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      lat_wdata <= '0;
      Prdata    <= '0;
      Pready    <= 1'b0;
      Pslverr   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      lat_idx   <= lat_idx_n;
      lat_write <= lat_write_n;
      lat_err   <= lat_err_n;
      lat_wdata <= lat_wdata_n;
      Prdata    <= prdata_n;
      Pready    <= pready_n;
      Pslverr   <= pslverr_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    lat_idx_n   = lat_idx;
    lat_write_n = lat_write;
    lat_err_n   = lat_err;
    lat_wdata_n = lat_wdata;
    prdata_n    = Prdata;
    pready_n    = Pready;
    pslverr_n   = Pslverr;
    we          = 1'b0;

    unique case (state)
      IDLE: begin
        if (Psel && !Penable) begin
          lat_idx_n   = idx_in;
          lat_write_n = Pwrite;
          lat_err_n   = err_in;
          lat_wdata_n = Pwdata;
          if (WAIT_CYCLES == 0) begin
            state_n   = READY;
            pready_n  = 1'b1;
            pslverr_n = src_err;
            prdata_n  = (!src_write && !src_err) ? rdata : '0;
          end else begin
            state_n = WAIT;
            cnt_n   = CNT_W'(WAIT_CYCLES);
          end
        end
      end

      WAIT: begin
        if (!Psel) begin
          state_n = IDLE;
        end else if (Penable) begin
          cnt_n = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state_n   = READY;
            pready_n  = 1'b1;
            pslverr_n = src_err;
            prdata_n  = (!src_write && !src_err) ? rdata : '0;
          end
        end
      end

      READY: begin
        if (!Psel || Penable) begin
          we        = Psel && lat_write && !lat_err;
          state_n   = IDLE;
          pready_n  = 1'b0;
          pslverr_n = 1'b0;
          prdata_n  = '0;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: a zero-wait and a 3-wait instance checked every cycle against a transfer-level model.
module tb_apb_slave_mem;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          TMO   = 20;

  logic        clk = 1'b0;
  logic        reset   [2];
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  apb_slave_mem #(.DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset[0]), .Psel(psel[0]), .Penable(penable[0]), .Pwrite(pwrite[0]),
    .Paddr(paddr[0]), .Pwdata(pwdata[0]), .Prdata(prdata[0]), .Pready(pready[0]), .Pslverr(pslverr[0]));

  apb_slave_mem #(.DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .reset(reset[1]), .Psel(psel[1]), .Penable(penable[1]), .Pwrite(pwrite[1]),
    .Paddr(paddr[1]), .Pwdata(pwdata[1]), .Prdata(prdata[1]), .Pready(pready[1]), .Pslverr(pslverr[1]));

  function automatic int wcyc(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  // Legal iff a word-aligned byte address inside [BASE, BASE + 4*DEPTH).
  function automatic bit addr_err(input logic [31:0] a);
    longint unsigned la, lb;
    la = longint'(a);
    lb = longint'(BASE);
    return !(la >= lb && la < lb + 4 * DEPTH && (la % 4) == 0);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  // Transfer-level model: a transfer is pending from its setup edge until completion,
  // abort or reset; the response is due once WAIT_CYCLES access edges have passed.
  bit          m_active [2] = '{0, 0};
  int          m_done   [2] = '{0, 0};
  logic [31:0] m_addr   [2];
  bit          m_write  [2];
  logic [31:0] m_wdata  [2];
  logic [31:0] m_mem    [2][DEPTH];

  initial begin
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < DEPTH; k++) m_mem[i][k] = '0;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset[i]) begin
        m_active[i] <= 0;
        for (int k = 0; k < DEPTH; k++) m_mem[i][k] <= '0;
      end else if (!m_active[i]) begin
        if (psel[i] && !penable[i]) begin
          m_active[i] <= 1;
          m_done[i]   <= 0;
          m_addr[i]   <= paddr[i];
          m_write[i]  <= pwrite[i];
          m_wdata[i]  <= pwdata[i];
        end
      end else if (!psel[i]) begin
        m_active[i] <= 0;
      end else if (penable[i]) begin
        if (m_done[i] >= wcyc(i)) begin
          if (m_write[i] && !addr_err(m_addr[i])) m_mem[i][word_of(m_addr[i])] <= m_wdata[i];
          m_active[i] <= 0;
        end else begin
          m_done[i] <= m_done[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit          ep, ee;
      logic [31:0] ed;
      ep = m_active[i] && (m_done[i] >= wcyc(i));
      ee = ep && addr_err(m_addr[i]);
      ed = (ep && !m_write[i] && !ee) ? m_mem[i][word_of(m_addr[i])] : 32'h0;
      vectors++;
      if (pready[i] !== ep || pslverr[i] !== ee || prdata[i] !== ed) begin
        miscompares++;
        $display("FAIL cycle inst%0d t=%0t: got ready=%b err=%b rdata=%h, need ready=%b err=%b rdata=%h",
                 i, $time, pready[i], pslverr[i], prdata[i], ep, ee, ed);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, need %h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the completion edge with the bus idle.
  task automatic xfer(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int waits);
    psel[i] = 1; penable[i] = 0; pwrite[i] = wr; paddr[i] = a; pwdata[i] = d;
    @(posedge clk); #1;
    penable[i] = 1;
    paddr[i] = $urandom; pwdata[i] = $urandom;
    waits = 0;
    while (pready[i] !== 1'b1 && waits < TMO) begin
      @(posedge clk); #1;
      waits++;
    end
    if (waits >= TMO) begin
      vectors++; miscompares++;
      $display("FAIL timeout inst%0d: no Pready within %0d cycles", i, TMO);
    end
    rd = prdata[i];
    er = pslverr[i];
    @(posedge clk); #1;
    check("pready_one_cycle", 32'(pready[i]), 32'h0);
    psel[i] = 0; penable[i] = 0;
  endtask

  task automatic abort_xfer(input int i, input logic [31:0] a, input logic [31:0] d, input int k);
    psel[i] = 1; penable[i] = 0; pwrite[i] = 1; paddr[i] = a; pwdata[i] = d;
    @(posedge clk); #1;
    for (int j = 0; j < k; j++) begin
      penable[i] = 1;
      @(posedge clk); #1;
    end
    psel[i] = 0; penable[i] = 0;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0:       return BASE + ($urandom_range(0, 4 * DEPTH - 1) | 32'h1);
      1:       return BASE + 4 * DEPTH + 4 * $urandom_range(0, 15);
      2:       return BASE - 4 * $urandom_range(1, 4);
      default: return BASE + 4 * $urandom_range(0, DEPTH - 1);
    endcase
  endfunction

  logic [31:0] rd;
  logic        er;
  int          w;

  initial begin
    for (int i = 0; i < 2; i++) begin
      reset[i] = 1; psel[i] = 0; penable[i] = 0; pwrite[i] = 0; paddr[i] = '0; pwdata[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_pready0", 32'(pready[0]), 32'h0);
    check("reset_prdata1", prdata[1], 32'h0);
    reset[0] = 0; reset[1] = 0;
    @(posedge clk); #1;

    // Zero-wait write then read.
    xfer(0, 1, 32'h8000_0010, 32'hDEAD_BEEF, rd, er, w);
    check("zw_write_waits", 32'(w), 32'd0);
    check("zw_write_err", 32'(er), 32'h0);
    xfer(0, 0, 32'h8000_0010, 32'h0, rd, er, w);
    check("zw_read_waits", 32'(w), 32'd0);
    check("zw_read_data", rd, 32'hDEAD_BEEF);

    // Three wait states on a fresh read.
    xfer(1, 0, 32'h8000_0000, 32'h0, rd, er, w);
    check("w3_read_waits", 32'(w), 32'd3);
    check("w3_read_data", rd, 32'h0);

    // Out-of-range write is dropped; last word stays 0.
    xfer(1, 1, 32'h8000_0100, 32'hFFFF_FFFF, rd, er, w);
    check("oor_write_err", 32'(er), 32'h1);
    check("oor_write_waits", 32'(w), 32'd3);
    xfer(1, 0, 32'h8000_00FC, 32'h0, rd, er, w);
    check("last_word", rd, 32'h0);
    check("last_word_err", 32'(er), 32'h0);

    // Misaligned read.
    xfer(0, 0, 32'h8000_0002, 32'h0, rd, er, w);
    check("misaligned_err", 32'(er), 32'h1);
    check("misaligned_data", rd, 32'h0);

    // Psel dropped while waiting: no commit.
    abort_xfer(1, 32'h8000_0004, 32'h1234_5678, 1);
    xfer(1, 0, 32'h8000_0004, 32'h0, rd, er, w);
    check("abort_readback", rd, 32'h0);

    // Reset while READY on a write.
    psel[1] = 1; penable[1] = 0; pwrite[1] = 1; paddr[1] = 32'h8000_0008; pwdata[1] = 32'hCAFE_F00D;
    @(posedge clk); #1;
    penable[1] = 1;
    w = 0;
    while (pready[1] !== 1'b1 && w < TMO) begin
      @(posedge clk); #1;
      w++;
    end
    check("rst_ready_reached", 32'(pready[1]), 32'h1);
    reset[1] = 1; psel[1] = 0; penable[1] = 0;
    @(posedge clk); #1;
    check("rst_pready", 32'(pready[1]), 32'h0);
    check("rst_pslverr", 32'(pslverr[1]), 32'h0);
    check("rst_prdata", prdata[1], 32'h0);
    reset[1] = 0;
    @(posedge clk); #1;
    xfer(1, 0, 32'h8000_0008, 32'h0, rd, er, w);
    check("rst_readback", rd, 32'h0);

    // Back-to-back writes on both instances, then readback.
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 3; k++) xfer(i, 1, BASE + 4 * k, 32'hA5A5_0000 + k, rd, er, w);
      for (int k = 0; k < 3; k++) begin
        xfer(i, 0, BASE + 4 * k, 32'h0, rd, er, w);
        check("b2b_readback", rd, 32'hA5A5_0000 + k);
      end
    end

    // Randomized traffic, checked by the per-cycle model.
    for (int n = 0; n < 300; n++) begin
      int i;
      i = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0)
        abort_xfer(i, rand_addr(), $urandom, (i == 0) ? 0 : $urandom_range(0, 2));
      else
        xfer(i, 1'($urandom_range(0, 1)), rand_addr(), $urandom, rd, er, w);
    end

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
